// File: rtl/alu_pkg.sv
// Shared ALU control encodings and EX-unit FSM states; also imported by the ALU control decoder.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } exec_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiplier (shift-add) / signed divider (restoring), one step per cycle, XLEN steps.
// res/done are combinational during the final step so the caller latches the result on that edge.
module alu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            busy_q, busy_d;
  logic            div_q, div_d;
  logic            neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] x_q, x_d;
  logic [XLEN-1:0] y_q, y_d;

  logic [XLEN-1:0] a_mag, b_mag, mul_acc, q_next;
  logic [XLEN:0]   rem_sh, diff;
  logic            qbit;

  always_comb begin
    a_mag   = a[XLEN-1] ? (~a + 1'b1) : a;
    b_mag   = b[XLEN-1] ? (~b + 1'b1) : b;
    mul_acc = acc_q + (y_q[0] ? x_q : '0);
    // acc holds the partial remainder, y shifts the dividend out and quotient bits in
    rem_sh  = {acc_q, y_q[XLEN-1]};
    diff    = rem_sh - {1'b0, x_q};
    qbit    = ~diff[XLEN];
    q_next  = {y_q[XLEN-2:0], qbit};
  end

  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    if (start) begin
      busy_d = 1'b1;
      div_d  = is_div;
      neg_d  = is_div & (a[XLEN-1] ^ b[XLEN-1]);
      cnt_d  = '0;
      acc_d  = '0;
      x_d    = is_div ? b_mag : a;
      y_d    = is_div ? a_mag : b;
    end else if (busy_q) begin
      if (div_q) begin
        acc_d = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        y_d   = q_next;
      end else begin
        acc_d = mul_acc;
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST);
  assign res  = div_q ? (neg_q ? (~q_next + 1'b1) : q_next) : mul_acc;

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: add/sub/and/or/illegal in 1 cycle, mul/div in XLEN+1; valid/ready both sides,
// in_ready only in IDLE, result and flags held in DONE until out_ready.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            div_by_zero,
  output logic            illegal_op
);

  exec_state_e     state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            dbz_q, dbz_d;
  logic            ill_q, ill_d;

  logic            accept, md_start, md_busy, md_done;
  logic [XLEN-1:0] md_res;

  assign accept = in_valid & in_ready;

  alu_muldiv_seq #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (alu_ctrl == ALU_DIV),
    .a      (op_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .res    (md_res)
  );

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    md_start = 1'b0;
    if (accept) begin
      result_d = '0;
      dbz_d    = 1'b0;
      ill_d    = 1'b0;
      unique case (alu_ctrl)
        ALU_ADD: result_d = op_a + op_b;
        ALU_SUB: result_d = op_a - op_b;
        ALU_AND: result_d = op_a & op_b;
        ALU_OR:  result_d = op_a | op_b;
        ALU_MUL: md_start = 1'b1;
        // divide-by-zero short-circuits the iteration entirely
        ALU_DIV: begin
          if (op_b == '0) begin
            result_d = '1;
            dbz_d    = 1'b1;
          end else begin
            md_start = 1'b1;
          end
        end
        default: ill_d = 1'b1;
      endcase
      zero_d = (result_d == '0);
    end else if (state_q == ST_BUSY && md_done) begin
      result_d = md_res;
      zero_d   = (md_res == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = md_start ? ST_BUSY : ST_DONE;
      ST_BUSY: if (md_busy && md_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    out_valid   = (state_q == ST_DONE);
    result      = result_q;
    zero        = zero_q;
    div_by_zero = dbz_q;
    illegal_op  = ill_q;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, div_by_zero, illegal_op;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op; lat = edges from accept to out_valid; rdy_seen counts in_ready=1 while waiting.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int rdy_seen);
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_ctrl = 4'b0010; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    lat = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input string tag);
    @(posedge clk); #1;
    chk({tag, "_ovalid_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic [3:0]  c;
    logic [31:0] a, b, res;
    logic        z, dbz, ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int lat, rdy;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_ctrl = 4'b0; op_a = '0; op_b = '0; out_ready = 1'b1;
    #1;
    chk("rst_ovalid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'b0, zero, div_by_zero, illegal_op}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_inready", {31'b0, in_ready}, 32'd1);

    vecs.push_back('{"add_7_5",   4'b0010, 32'd7,        32'd5,        32'd12,       1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"sub_9_9",   4'b0110, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{"or_a_5",    4'b0001, 32'h0000_00A0, 32'h5,       32'h0000_00A5, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'd2,       32'd1,        1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"mul_ff_3",  4'b0111, 32'hFFFF_FFFF, 32'd3,       32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{"mul_6_7",   4'b0111, 32'd6,        32'd7,        32'd42,       1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{"div_m7_2",  4'b0100, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{"div_min_m1",4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{"div_100_7", 4'b0100, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{"div_5_0",   4'b0100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{"div_1_5",   4'b0100, 32'd1,        32'd5,        32'd0,        1'b1, 1'b0, 1'b0, 33});
    vecs.push_back('{"illegal",   4'b1111, 32'd3,        32'd4,        32'd0,        1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{"or_clr_ill",4'b0001, 32'd0,        32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1});

    foreach (vecs[i]) begin
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, lat, rdy);
      chk({vecs[i].tag, "_lat"}, lat, vecs[i].lat);
      chk({vecs[i].tag, "_res"}, result, vecs[i].res);
      chk({vecs[i].tag, "_flags"}, {29'b0, vecs[i].z, vecs[i].dbz, vecs[i].ill},
          {29'b0, zero, div_by_zero, illegal_op});
      if (vecs[i].lat > 1) chk({vecs[i].tag, "_busy_rdy"}, rdy, 0);
      drain(vecs[i].tag);
    end

    // Backpressure: result held while out_ready low; new requests ignored.
    out_ready = 1'b0;
    run_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, lat, rdy);
    chk("bp_lat", lat, 1);
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd100; op_b = 32'd200;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", result, 32'h0000_F000);
      chk("bp_hold_vld", {30'b0, out_valid, in_ready}, 32'd2);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    drain("bp");

    // Reset mid-MUL aborts with no output.
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'b0111; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ovalid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags", {29'b0, zero, div_by_zero, illegal_op}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(4'b0010, 32'd1, 32'd1, lat, rdy);
    chk("postrst_lat", lat, 1);
    chk("postrst_res", result, 32'd2);
    drain("postrst");
    repeat (40) @(posedge clk);
    #1 chk("postrst_no_stale", {31'b0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
